// File: rtl/shift_engine.sv
// -----------------------------------------------------------------------------
// shift_engine
// -----------------------------------------------------------------------------
// Full-duplex serial shift engine for the SPI datapath.
//
// A parallel word is accepted through a valid/ready handshake. It is shifted
// out one bit per shift_en strobe, and the incoming serial bits are assembled
// into a received word at the same time. After exactly WIDTH strobes the
// received word appears on rx_data, together with a one-cycle rx_valid pulse.
// shift_en comes from the SPI bit-timing logic. The byte-level controller
// drives the tx handshake and consumes rx_data.
//
// Parameters
//   WIDTH      word length in bits, 1..32
//   LSB_FIRST  0: MSB transmitted/received first, 1: LSB first
//
// Optional build macro
//   SHIFT_ENGINE_DOUBLE_BUF_EN  adds a one-word holding register. A second
//                               word can then be queued while one is shifting,
//                               which gives back-to-back transfers with no
//                               idle cycles between words.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   tx_data    in   [WIDTH]  word to transmit
//   tx_valid   in   tx_data valid
//   tx_ready   out  engine accepts tx_data this cycle
//   shift_en   in   bit strobe, one bit per asserted cycle
//   shift_in   in   serial receive bit, sampled when shift_en=1
//   shift_out  out  current serial transmit bit
//   abort      in   cancel the word in progress
//   rx_data    out  [WIDTH]  last completed received word
//   rx_valid   out  one-cycle pulse when rx_data updates
//   busy       out  word in progress
//   bit_count  out  [$clog2(WIDTH+1)]  bits shifted in the current word
// -----------------------------------------------------------------------------
module shift_engine #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  input  logic                       shift_en,
  input  logic                       shift_in,
  output logic                       shift_out,
  input  logic                       abort,
  output logic [WIDTH-1:0]           rx_data,
  output logic                       rx_valid,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_count
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   shreg_q;    // transmit bits leave, receive bits enter
  logic [WIDTH-1:0]   rx_data_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               rx_valid_q;

  // One shift step. The transmit bit leaves at one end of the register and
  // the receive bit enters at the other end. After WIDTH steps the register
  // therefore holds the complete received word in its natural bit order.
  logic [WIDTH-1:0]   shreg_shifted;

  generate
    if (WIDTH == 1) begin : g_w1
      assign shreg_shifted = shift_in;
    end else if (LSB_FIRST) begin : g_lsb
      assign shreg_shifted = {shift_in, shreg_q[WIDTH-1:1]};
    end else begin : g_msb
      assign shreg_shifted = {shreg_q[WIDTH-2:0], shift_in};
    end
  endgenerate

  // The first transmit bit is driven straight from the loaded register. It is
  // therefore valid in the cycle after the load, before any strobe arrives.
  assign shift_out = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];

  // The last strobe of the word. abort takes priority over a simultaneous
  // strobe, so a strobe that coincides with abort never completes a word.
  logic last_strobe;
  assign last_strobe = (state_q == SHIFT) && !abort && shift_en && (cnt_q == LAST_BIT);

`ifdef SHIFT_ENGINE_DOUBLE_BUF_EN
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic             accept;

  // The holding register decides readiness in every state. While the engine
  // is idle the holding register is always empty.
  assign tx_ready = !hold_full_q;
  assign accept   = tx_valid && tx_ready;

  // NOTE: hold_q is a pure data register and has no reset. hold_full_q alone
  // says whether hold_q is meaningful, so clearing the data would add nothing.
  always_ff @(posedge clk) begin
    if (accept && (state_q == SHIFT) && !abort && !last_strobe) begin
      hold_q <= tx_data;
    end
  end
`else
  assign tx_ready = (state_q == IDLE);
`endif

  // NOTE: all state here is updated with non-blocking assignments. Every
  // right-hand side therefore reads the pre-edge value, whatever the
  // statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      cnt_q      <= '0;
      rx_valid_q <= 1'b0;
`ifdef SHIFT_ENGINE_DOUBLE_BUF_EN
      hold_full_q <= 1'b0;
`endif
    end else begin
      rx_valid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          // Strobes and abort are meaningless without a word in flight.
          if (tx_valid) begin
            shreg_q <= tx_data;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end

        SHIFT: begin
          if (abort) begin
            // The partial word is discarded. rx_data keeps the last
            // completed word.
            cnt_q   <= '0;
            state_q <= IDLE;
`ifdef SHIFT_ENGINE_DOUBLE_BUF_EN
            // A queued word, or one offered in this same cycle, goes with it.
            hold_full_q <= 1'b0;
`endif
          end else begin
            if (shift_en) begin
              shreg_q <= shreg_shifted;
              if (cnt_q == LAST_BIT) begin
                rx_data_q  <= shreg_shifted;
                rx_valid_q <= 1'b1;
                cnt_q      <= '0;
`ifdef SHIFT_ENGINE_DOUBLE_BUF_EN
                // Chain straight into the next word, with no idle cycle.
                // A word offered on this very edge skips the holding register.
                if (hold_full_q) begin
                  shreg_q     <= hold_q;
                  hold_full_q <= 1'b0;
                end else if (accept) begin
                  shreg_q <= tx_data;
                end else begin
                  state_q <= IDLE;
                end
`else
                state_q <= IDLE;
`endif
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
`ifdef SHIFT_ENGINE_DOUBLE_BUF_EN
            // A word offered mid-word waits until the current one completes.
            if (accept && !last_strobe) begin
              hold_full_q <= 1'b1;
            end
`endif
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = (state_q == SHIFT);
  assign bit_count = cnt_q;

endmodule

// File: doc/shift_engine.md
Name: shift_engine

Overview:
Parametrised full-duplex serial shift engine for the SPI datapath. It accepts a parallel word through a valid/ready handshake and shifts it out one bit per `shift_en` strobe, while assembling the incoming serial bits into a received word. After exactly WIDTH strobes it reports the received word with a single-cycle `rx_valid` pulse. It sits between the SPI bit-timing logic, which generates `shift_en`, and the byte-level controller.

Parameters:
WIDTH, 8, word length in bits; legal range 1..32.
LSB_FIRST, 0, 0 = MSB transmitted and received first; 1 = LSB first.

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  synchronous, active-low reset
tx_data  input  WIDTH  word to transmit
tx_valid  input  1  tx_data is valid
tx_ready  output  1  engine can accept tx_data this cycle
shift_en  input  1  bit strobe, one bit per asserted cycle
shift_in  input  1  serial receive bit, sampled when shift_en=1
shift_out  output  1  current serial transmit bit
abort  input  1  cancel the current word
rx_data  output  WIDTH  last completed received word
rx_valid  output  1  one-cycle pulse when rx_data updates
busy  output  1  high while a word is in progress
bit_count  output  $clog2(WIDTH+1)  number of bits shifted in the current word

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - Shift register, rx_data and bit_count clear to 0.
  - rx_valid=0, busy=0, tx_ready=1, shift_out=0.
  - Reset overrides all other inputs, including mid-word; a partial word is discarded with no rx_valid.
- State IDLE:
  - busy=0, tx_ready=1.
  - shift_en is ignored.
  - tx_valid=1 loads tx_data into the shift register, clears bit_count and moves to SHIFT.
- shift_out:
  - Combinational from the shift register: bit [WIDTH-1] when LSB_FIRST=0, bit [0] when LSB_FIRST=1.
  - The first bit is therefore valid in the cycle after the load, before any strobe.
- State SHIFT:
  - busy=1, tx_ready=0 (base build).
  - Each cycle with shift_en=1:
    - LSB_FIRST=0: register <= {reg[WIDTH-2:0], shift_in}.
    - LSB_FIRST=1: register <= {shift_in, reg[WIDTH-1:1]}.
    - bit_count increments.
  - WIDTH=1: the register is simply replaced by shift_in.
- Word completion:
  - Triggered by a shift_en in SHIFT with bit_count==WIDTH-1.
  - On that edge: rx_data <= the fully shifted value, rx_valid=1 for exactly the following cycle, bit_count <= 0, state -> IDLE.
  - Latency from load to rx_valid = WIDTH strobes + 1 clk.
- Abort:
  - abort=1 in SHIFT returns to IDLE on the next edge and clears bit_count.
  - No rx_valid; rx_data is unchanged.
  - abort has priority over a simultaneous shift_en.
  - abort in IDLE has no effect.
- Simultaneous events:
  - tx_valid is ignored while tx_ready=0.
  - In the base build, no load can coincide with a completion.
- rx_data holds its value until the next completion.

Optional Feature:
- Macro: SHIFT_ENGINE_DOUBLE_BUF_EN. When defined, a one-word holding register is added for back-to-back transfers.
- Holding register behaviour:
  - tx_ready = holding register empty, in any state.
  - An accepted word goes straight to the shift register if in IDLE; otherwise it waits in the holding register.
  - On completion with the holding register full:
    - rx_valid pulses as normal.
    - The held word loads into the shift register on the same edge.
    - bit_count clears, state stays SHIFT and busy stays 1, so there are zero idle cycles.
    - The holding register empties, so tx_ready=1 on the next cycle.
  - abort returns to IDLE and also empties the holding register.
  - Reset empties the holding register.
- Without the macro: exactly the base behaviour, with no holding register logic.

Test Plan:
- WIDTH=8, LSB_FIRST=0; load 0xA5; 8 strobes with shift_in sequence 1,1,0,0,0,0,1,1 -> shift_out sequence 1,0,1,0,0,1,0,1; rx_data=0xC3; rx_valid high exactly 1 cycle, 1 clk after the 8th strobe; busy drops with it.
- LSB_FIRST=1; load 0x01; shift_in=1 on all 8 strobes -> shift_out sequence 1,0,0,0,0,0,0,0; rx_data=0xFF.
- Strobes spaced by 3 idle clk plus shift_en pulses issued in IDLE -> bit_count only advances on strobes in SHIFT; final result is identical to the back-to-back case.
- Load 0x5A, 4 strobes, then abort together with shift_en -> IDLE next cycle, bit_count=0, no rx_valid, rx_data keeps its previous value; a fresh load of 0x3C then completes normally.
- rst_n=0 for one clk after 5 strobes -> all outputs at reset values; tx_valid asserted in the same cycle is not accepted.
- With SHIFT_ENGINE_DOUBLE_BUF_EN: load 0x11, then 0x22 one cycle later (accepted, tx_ready falls) -> two rx_valid pulses exactly 8 strobes apart; busy never deasserts between the words; tx_ready=1 the cycle after the first completion.
